// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU bus between the register-read stage, the ALU issue controller,
// the combinational ALU and writeback.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [DATA_W-1:0] in_rn;
    logic [DATA_W-1:0] in_rm;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic              out_branch;
    logic              out_illegal;

    modport master (
        output in_valid, in_instr, in_rn, in_rm, alu_result, alu_zero, out_ready,
        input  in_ready, alu_op, alu_a, alu_b, out_valid, out_result, out_zero,
               out_branch, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_rn, in_rm, alu_result, alu_zero, out_ready,
        output in_ready, alu_op, alu_a, alu_b, out_valid, out_result, out_zero,
               out_branch, out_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// LEGv8 ALU issue controller: accepts instr+operands, decodes to ALU op/operands,
// captures the ALU result and zero flag, and hands them off with a CBZ decision.
module alu_issue_ctrl #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_ctrl_if.slave  bus,
    output logic [CNT_W-1:0] retired
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]        state;
    logic [31:0]       instr_q;
    logic [DATA_W-1:0] rn_q;
    logic [DATA_W-1:0] rm_q;
    logic              cbz_q;

    logic [2:0]        alu_op_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              branch_q;
    logic              illegal_q;

    logic              dec_legal;
    logic              dec_cbz;
    logic [2:0]        dec_op;
    logic [DATA_W-1:0] dec_a;
    logic [DATA_W-1:0] dec_b;

    always_comb begin
        dec_legal = 1'b1;
        dec_cbz   = 1'b0;
        dec_op    = 3'b000;
        dec_a     = rn_q;
        dec_b     = rm_q;
        casez (instr_q[31:21])
            11'b10001011000: dec_op = 3'b000;
            11'b11001011000: dec_op = 3'b001;
            11'b10001010000: dec_op = 3'b010;
            11'b10101010000: dec_op = 3'b011;
            11'b11010011011: begin
                dec_op = 3'b101;
                dec_b  = DATA_W'(instr_q[15:0]);
            end
            11'b11010011010: begin
                dec_op = 3'b110;
                dec_b  = DATA_W'(instr_q[15:0]);
            end
            11'b1001000100?: begin
                dec_op = 3'b000;
                dec_b  = DATA_W'(instr_q[21:10]);
            end
            11'b1101000100?: begin
                dec_op = 3'b001;
                dec_b  = DATA_W'(instr_q[21:10]);
            end
            11'b11111000010,
            11'b11111000000: begin
                dec_op = 3'b000;
                dec_b  = DATA_W'($signed(instr_q[20:12]));
            end
            11'b10110100???: begin
                dec_op  = 3'b100;
                dec_a   = '0;
                dec_cbz = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            instr_q   <= '0;
            rn_q      <= '0;
            rm_q      <= '0;
            cbz_q     <= 1'b0;
            alu_op_q  <= 3'b000;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        instr_q <= bus.in_instr;
                        rn_q    <= bus.in_rn;
                        rm_q    <= bus.in_rm;
                        state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    // Illegal opcodes skip the ALU entirely; alu_* keep the last issue.
                    if (dec_legal) begin
                        alu_op_q <= dec_op;
                        alu_a_q  <= dec_a;
                        alu_b_q  <= dec_b;
                        cbz_q    <= dec_cbz;
                        state    <= ST_EXEC;
                    end else begin
                        illegal_q <= 1'b1;
                        result_q  <= '0;
                        zero_q    <= 1'b0;
                        branch_q  <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_EXEC: begin
                    result_q  <= bus.alu_result;
                    zero_q    <= bus.alu_zero;
                    branch_q  <= cbz_q & bus.alu_zero;
                    illegal_q <= 1'b0;
                    state     <= ST_DONE;
                end
                default: begin
                    if (bus.out_ready) begin
                        retired <= retired + CNT_W'(1);
                        state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready    = (state == ST_IDLE);
    assign bus.out_valid   = (state == ST_DONE);
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.out_result  = result_q;
    assign bus.out_zero    = zero_q;
    assign bus.out_branch  = branch_q;
    assign bus.out_illegal = illegal_q;
endmodule
